wb_timeout_slice: RTL

//  Registered Wishbone classic slice on the 32-bit side of the 128->32 down-bridge. It sits between
//  the bridge's narrow master port and the 32-bit peripheral bus. It breaks the combinational request
//  and response paths and ends any access left unacked for TIMEOUT cycles with a bus error.

---
 rtl/wb_timeout_slice.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/wb_timeout_slice.sv
// wb_timeout_slice: registered Wishbone classic slice that ends unacked accesses with a bus error.
// Optional timeout status outputs (o_to_count, o_to_adr) enabled by WB_TIMEOUT_SLICE_STATUS_EN.
`default_nettype none

module wb_timeout_slice #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int SW      = DW >> 3,
   parameter int TIMEOUT = 255,
   parameter int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [AW-1:0] i_s_wb_adr,
   input  logic [SW-1:0] i_s_wb_sel,
   input  logic          i_s_wb_we,
   input  logic [DW-1:0] i_s_wb_dat,
   output logic [DW-1:0] o_s_wb_dat,
   input  logic          i_s_wb_cyc,
   input  logic          i_s_wb_stb,
   output logic          o_s_wb_ack,
   output logic          o_s_wb_err,
   output logic [AW-1:0] o_m_wb_adr,
   output logic [SW-1:0] o_m_wb_sel,
   output logic          o_m_wb_we,
   output logic [DW-1:0] o_m_wb_dat,
   input  logic [DW-1:0] i_m_wb_dat,
   output logic          o_m_wb_cyc,
   output logic          o_m_wb_stb,
   input  logic          i_m_wb_ack,
   input  logic          i_m_wb_err
`ifdef WB_TIMEOUT_SLICE_STATUS_EN
   ,
   output logic [15:0]   o_to_count,
   output logic [AW-1:0] o_to_adr
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [SW-1:0] sel_q, sel_d;
   logic          we_q, we_d;
   logic [DW-1:0] wdat_q, wdat_d;
   logic [DW-1:0] rdat_q, rdat_d;
   logic          err_q, err_d;
`ifdef WB_TIMEOUT_SLICE_STATUS_EN
   logic          to_event;
   logic [15:0]   to_count_q;
   logic [AW-1:0] to_adr_q;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      sel_d   = sel_q;
      we_d    = we_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      err_d   = err_q;
`ifdef WB_TIMEOUT_SLICE_STATUS_EN
      to_event = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_s_wb_cyc && i_s_wb_stb) begin
               adr_d   = i_s_wb_adr;
               sel_d   = i_s_wb_sel;
               we_d    = i_s_wb_we;
               wdat_d  = i_s_wb_dat;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            // Abort outranks any response; peripheral err outranks ack and timeout.
            if (!i_s_wb_cyc) begin
               state_d = S_IDLE;
            end else if (i_m_wb_err) begin
               err_d   = 1'b1;
               state_d = S_RESP;
            end else if (i_m_wb_ack) begin
               err_d   = 1'b0;
               if (!we_q) rdat_d = i_m_wb_dat;
               state_d = S_RESP;
            end else if (cnt_q == LAST_CNT) begin
               err_d   = 1'b1;
               state_d = S_RESP;
`ifdef WB_TIMEOUT_SLICE_STATUS_EN
               to_event = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign o_m_wb_cyc = (state_q == S_BUSY);
   assign o_m_wb_stb = (state_q == S_BUSY);
   assign o_m_wb_adr = adr_q;
   assign o_m_wb_sel = sel_q;
   assign o_m_wb_we  = we_q;
   assign o_m_wb_dat = wdat_q;
   assign o_s_wb_dat = rdat_q;
   assign o_s_wb_ack = (state_q == S_RESP) && !err_q;
   assign o_s_wb_err = (state_q == S_RESP) && err_q;

`ifdef WB_TIMEOUT_SLICE_STATUS_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         to_count_q <= '0;
         to_adr_q   <= '0;
      end else if (to_event) begin
         if (to_count_q != 16'hFFFF) to_count_q <= to_count_q + 16'd1;
         to_adr_q <= adr_q;
      end
   end

   assign o_to_count = to_count_q;
   assign o_to_adr   = to_adr_q;
`endif

endmodule

`default_nettype wire
